// File: rtl/key_led_ctrl.sv
// ---------------------------------------------------------------------------
// key_led_ctrl
//
// Per-channel push-button to LED controller. Each key is synchronised,
// debounced and edge-detected. Every press steps that channel's mode
// OFF -> ON -> BLINK -> OFF. All blinking channels share one phase
// generator, so they blink in step with each other.
//
// Optional feature macro: KLED_LONGPRESS_EN
//   When defined, holding any debounced key low for LONG_CYC cycles
//   forces every channel to OFF. This happens once per hold, and the
//   feature re-arms only after that key is released.
//
// Parameters
//   NCH      : number of key/LED channels (1..16)
//   TICK_CYC : blink half-period in clk cycles (>= 2)
//   DEB_CYC  : debounce stability window in clk cycles (>= 1)
//   LONG_CYC : long-press threshold in clk cycles (long-press build only)
//
// Ports
//   clk   : system clock, sole clock domain
//   rst   : synchronous active-high reset
//   key   : [NCH-1:0]   asynchronous active-low push buttons (0 = pressed)
//   led   : [NCH-1:0]   registered active-high LED drive
//   mode  : [2*NCH-1:0] registered channel modes, channel i at [2i+1:2i]
//           (OFF=0, ON=1, BLINK=2)
// ---------------------------------------------------------------------------
module key_led_ctrl #(
    parameter int NCH      = 4,
    parameter int TICK_CYC = 10_000_000,
    parameter int DEB_CYC  = 1_000_000,
    parameter int LONG_CYC = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   key,
    output logic [NCH-1:0]   led,
    output logic [2*NCH-1:0] mode
);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        ON    = 2'd1,
        BLINK = 2'd2
    } mode_t;

    localparam int                TICK_W    = $clog2(TICK_CYC);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam int                DEB_W     = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);

    logic [TICK_W-1:0] tick_cnt_reg;
    logic              phase_reg;
    logic              all_off;

    // Shared blink time base: the counter wraps and the phase flips together.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_reg <= '0;
            phase_reg    <= 1'b0;
        end else if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_reg <= '0;
            phase_reg    <= ~phase_reg;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

`ifdef KLED_LONGPRESS_EN
    localparam int                LONG_W    = (LONG_CYC > 1) ? $clog2(LONG_CYC) : 1;
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

    logic [NCH-1:0] lp_hit;

    assign all_off = |lp_hit;
`else
    // LONG_CYC has no effect in this build. This comparison is always false,
    // so all_off is tied low.
    assign all_off = (LONG_CYC < 0);
`endif

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic             sync1_reg;
        logic             sync2_reg;
        logic             deb_reg;
        logic             deb_d_reg;
        logic             press_reg;
        logic [DEB_W-1:0] deb_cnt_reg;
        logic             led_reg;
        mode_t            mode_reg;
        mode_t            mode_next;

        // The synchroniser feeds the debouncer. The press pulse is registered
        // one cycle after the debounced falling edge. That extra stage sets the
        // fixed latency from key to mode.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_reg   <= 1'b1;
                sync2_reg   <= 1'b1;
                deb_reg     <= 1'b1;
                deb_d_reg   <= 1'b1;
                press_reg   <= 1'b0;
                deb_cnt_reg <= '0;
            end else begin
                sync1_reg <= key[gi];
                sync2_reg <= sync1_reg;
                deb_d_reg <= deb_reg;
                press_reg <= deb_d_reg & ~deb_reg;
                if (sync2_reg == deb_reg) begin
                    deb_cnt_reg <= '0;
                end else if (deb_cnt_reg == DEB_LAST) begin
                    deb_reg     <= sync2_reg;
                    deb_cnt_reg <= '0;
                end else begin
                    deb_cnt_reg <= deb_cnt_reg + 1'b1;
                end
            end
        end

`ifdef KLED_LONGPRESS_EN
        logic [LONG_W-1:0] lp_cnt_reg;
        logic              lp_fired_reg;

        // A hold fires once. lp_fired_reg blocks further hits until the
        // debounced key returns high, which clears both the counter and the flag.
        assign lp_hit[gi] = ~deb_reg & ~lp_fired_reg & (lp_cnt_reg == LONG_LAST);

        always_ff @(posedge clk) begin
            if (rst || deb_reg) begin
                lp_cnt_reg   <= '0;
                lp_fired_reg <= 1'b0;
            end else if (lp_hit[gi]) begin
                lp_fired_reg <= 1'b1;
            end else if (!lp_fired_reg) begin
                lp_cnt_reg <= lp_cnt_reg + 1'b1;
            end
        end
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_reg <= OFF;
            end else begin
                mode_reg <= mode_next;
            end
        end

        // A long-press all-off wins over a press pulse in the same cycle.
        always_comb begin
            mode_next = mode_reg;
            if (all_off) begin
                mode_next = OFF;
            end else begin
                case (mode_reg)
                    OFF:     if (press_reg) mode_next = ON;
                    ON:      if (press_reg) mode_next = BLINK;
                    BLINK:   if (press_reg) mode_next = OFF;
                    default: mode_next = OFF;
                endcase
            end
        end

        // The LED follows mode and phase one cycle later. So when both change
        // on the same edge, the LED shows the new values of each.
        always_ff @(posedge clk) begin
            if (rst) begin
                led_reg <= 1'b0;
            end else begin
                led_reg <= (mode_reg == ON) || ((mode_reg == BLINK) && phase_reg);
            end
        end

        assign mode[2*gi +: 2] = mode_reg;
        assign led[gi]         = led_reg;
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_key_led_ctrl
//
// Self-checking bench for key_led_ctrl (NCH=4, TICK_CYC=8, DEB_CYC=4,
// LONG_CYC=40).
//
// The stimulus process drives keys and reset at negedges. As it does so, it
// queues the expected {mode, led} value for specific clock edges. A separate
// monitor runs at every negedge. It pops each entry whose edge has arrived
// and compares it against the DUT outputs.
//
// Edge numbering: edge_cnt counts posedges. A key changed at the negedge where
// edge_cnt==E is first sampled at edge E+1. The mode then updates at
// E+1+DEB+3, and the LED one edge after that.
// Blink phase after edge e = ((e - last reset edge) / 8) & 1.
// ---------------------------------------------------------------------------
module tb_key_led_ctrl;

    localparam int NCH  = 4;
    localparam int TICK = 8;
    localparam int DEB  = 4;
    localparam int LONG = 40;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] key = 4'hF;
    logic [NCH-1:0] led;
    logic [2*NCH-1:0] mode;

    key_led_ctrl #(
        .NCH      (NCH),
        .TICK_CYC (TICK),
        .DEB_CYC  (DEB),
        .LONG_CYC (LONG)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .led  (led),
        .mode (mode)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int          ed;
        logic [7:0]  mode;
        logic [3:0]  led;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic expect_at(input int ed, input logic [7:0] m,
                             input logic [3:0] l, input string nm);
        exp_t e;
        e.ed   = ed;
        e.mode = m;
        e.led  = l;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int ed);
        while (edge_cnt < ed) @(negedge clk);
    endtask

    // Monitor: compares every queued expectation whose edge has been reached.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].ed <= edge_cnt) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.ed != edge_cnt) begin
                $display("FAIL %s: expectation for edge %0d reached only at edge %0d",
                         e.name, e.ed, edge_cnt);
            end else if (mode === e.mode && led === e.led) begin
                n_pass++;
                $display("edge %0d %s: mode=%h led=%b ok", edge_cnt, e.name, mode, led);
            end else begin
                $display("FAIL %s edge %0d: got mode=%h led=%b, expected mode=%h led=%b",
                         e.name, edge_cnt, mode, led, e.mode, e.led);
            end
        end
    end

    initial begin
        int end_ed;
        exp_t e;

        // Reset: held for edges 1..3 with all keys released.
        expect_at(1, 8'h00, 4'h0, "rst_e1");
        expect_at(2, 8'h00, 4'h0, "rst_e2");
        expect_at(3, 8'h00, 4'h0, "rst_e3");
        wait_to(3);
        rst = 1'b0;                           // last reset edge = 3

        // Press 1 on ch0: OFF -> ON. The mode changes at edge 13, the LED at edge 14.
        wait_to(5);
        key[0] = 1'b0;
        expect_at(12, 8'h00, 4'h0, "p1_before");
        expect_at(13, 8'h01, 4'h0, "p1_mode_on");
        expect_at(14, 8'h01, 4'h1, "p1_led_on");
        wait_to(15);
        key[0] = 1'b1;

        // Press 2 on ch0: ON -> BLINK at edge 33. The phase flips at edges 35, 43 and 51.
        wait_to(25);
        key[0] = 1'b0;
        expect_at(32, 8'h01, 4'h1, "p2_before");
        expect_at(33, 8'h02, 4'h1, "p2_mode_blink");
        expect_at(34, 8'h02, 4'h1, "p2_blink_hi");
        expect_at(36, 8'h02, 4'h0, "p2_blink_lo");
        expect_at(44, 8'h02, 4'h1, "p2_blink_hi2");
        expect_at(52, 8'h02, 4'h0, "p2_blink_lo2");
        wait_to(35);
        key[0] = 1'b1;

        // Press 3 on ch0: BLINK -> OFF at edge 61, while the phase is high.
        wait_to(53);
        key[0] = 1'b0;
        expect_at(60, 8'h02, 4'h1, "p3_before");
        expect_at(61, 8'h00, 4'h1, "p3_mode_off");
        expect_at(62, 8'h00, 4'h0, "p3_led_off");
        expect_at(70, 8'h00, 4'h0, "p3_stays_off");
        wait_to(63);
        key[0] = 1'b1;

        // Glitch on ch2: 3 low samples, shorter than DEB, so it is ignored.
        wait_to(73);
        key[2] = 1'b0;
        expect_at(80, 8'h00, 4'h0, "glitch_a");
        expect_at(85, 8'h00, 4'h0, "glitch_b");
        expect_at(90, 8'h00, 4'h0, "glitch_c");
        wait_to(76);
        key[2] = 1'b1;

        // All four keys pressed at once: every channel reaches ON on the same edge.
        wait_to(93);
        key = 4'h0;
        expect_at(100, 8'h00, 4'h0, "simul_before");
        expect_at(101, 8'h55, 4'h0, "simul_mode_on");
        expect_at(102, 8'h55, 4'hF, "simul_led_on");
        wait_to(103);
        key = 4'hF;

        // Exactly DEB low samples on ch3 is accepted: ON -> BLINK, with the phase low.
        wait_to(113);
        key[3] = 1'b0;
        expect_at(120, 8'h55, 4'hF, "deb_edge_before");
        expect_at(121, 8'h95, 4'hF, "deb_edge_mode");
        expect_at(122, 8'h95, 4'h7, "deb_edge_led");
        wait_to(117);
        key[3] = 1'b1;

        // Reset mid-debounce on ch1 (count 2 at edge 137), with the key held low.
        // The reset edge is 138, so re-debouncing gives ON at edge 139+7=146.
        wait_to(133);
        key[1] = 1'b0;
        expect_at(138, 8'h00, 4'h0, "mr_reset");
        expect_at(145, 8'h00, 4'h0, "mr_before");
        expect_at(146, 8'h04, 4'h0, "mr_mode_on");
        expect_at(147, 8'h04, 4'h2, "mr_led_on");
        wait_to(137);
        rst = 1'b1;
        wait_to(138);
        rst = 1'b0;
        wait_to(149);
        key[1] = 1'b1;
        end_ed = 160;

`ifdef KLED_LONGPRESS_EN
        // Put ch3 in ON, giving channels 1 and 3 ON.
        wait_to(160);
        key[3] = 1'b0;
        expect_at(167, 8'h04, 4'h2, "lp_ch3_before");
        expect_at(168, 8'h44, 4'h2, "lp_ch3_on");
        expect_at(169, 8'h44, 4'hA, "lp_ch3_led");
        wait_to(170);
        key[3] = 1'b1;

        // Hold key[0] for 60 cycles. The press turns ch0 ON at edge 188. The
        // debounced low starts after edge 186, and 40 held cycles later
        // (edge 226) every channel is forced OFF, once only.
        wait_to(180);
        key[0] = 1'b0;
        expect_at(187, 8'h44, 4'hA, "lp_before");
        expect_at(188, 8'h45, 4'hA, "lp_ch0_on");
        expect_at(189, 8'h45, 4'hB, "lp_led_on");
        expect_at(225, 8'h45, 4'hB, "lp_pre_fire");
        expect_at(226, 8'h00, 4'hB, "lp_all_off");
        expect_at(227, 8'h00, 4'h0, "lp_led_off");
        expect_at(239, 8'h00, 4'h0, "lp_no_refire");
        wait_to(240);
        key[0] = 1'b1;
        expect_at(250, 8'h00, 4'h0, "lp_after_release");
        end_ed = 255;
`endif

        wait_to(end_ed);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            $display("FAIL %s: expectation for edge %0d never compared", e.name, e.ed);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

endmodule
